// File: rtl/fetch_redirect_ctrl.sv
// Fetch/redirect controller: steers the fetch PC, injects NOP bubbles for boot and wrong-path slots.
// Optional macro REDIRECT_BYPASS_EN muxes the redirect target straight onto the fetch address.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_target,
    input  logic [31:0] i_inst_in,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_en,
    output logic [31:0] o_inst_id,
    output logic [31:0] o_pc_id,
    output logic        o_id_valid,
    output logic [31:0] o_redirect_cnt
);

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc_f;
    logic [31:0] r_pc_id;
    logic        r_kill_pending;
    logic [31:0] r_redirect_cnt;

    logic        w_redirect_acc;
    logic [31:0] w_target;
    logic [31:0] w_fetch_addr;
    logic [31:0] w_pc_f_nxt;
    logic        w_kill_nxt;
    logic        w_kill_slot;
    logic        w_unused_tgt_lsb;

    assign w_redirect_acc   = i_redirect_valid & ~i_stall;
    assign w_target         = {i_redirect_target[31:2], 2'b00};
    assign w_unused_tgt_lsb = ^i_redirect_target[1:0];

`ifdef REDIRECT_BYPASS_EN
    // Target goes straight to the memory this cycle, so no wrong-path fetch needs killing later.
    assign w_fetch_addr = w_redirect_acc ? w_target : r_pc_f;
    assign w_pc_f_nxt   = w_fetch_addr + 32'd4;
    assign w_kill_nxt   = 1'b0;
`else
    // The sequential fetch issued this cycle is wrong-path; kill_pending squashes it next cycle.
    assign w_fetch_addr = r_pc_f;
    assign w_pc_f_nxt   = w_redirect_acc ? w_target : (r_pc_f + 32'd4);
    assign w_kill_nxt   = w_redirect_acc;
`endif

    always_comb begin
        w_state_nxt = r_state;
        o_imem_addr = w_fetch_addr;
        o_imem_en   = ~i_stall;
        o_inst_id   = i_inst_in;
        o_id_valid  = 1'b1;
        w_kill_slot = (r_state == S_BOOT) | i_redirect_valid | r_kill_pending;
        if (!i_stall) begin
            w_state_nxt = S_RUN;
        end
        if (w_kill_slot) begin
            o_inst_id  = NOP_INST;
            o_id_valid = 1'b0;
        end
    end

    assign o_pc_id        = r_pc_id;
    assign o_redirect_cnt = r_redirect_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= S_BOOT;
            r_pc_f         <= RESET_PC;
            r_pc_id        <= 32'd0;
            r_kill_pending <= 1'b0;
            r_redirect_cnt <= 32'd0;
        end else if (!i_stall) begin
            r_state        <= w_state_nxt;
            r_pc_f         <= w_pc_f_nxt;
            r_pc_id        <= w_fetch_addr;
            r_kill_pending <= w_kill_nxt;
            if (w_redirect_acc) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: per-cycle vector table with expected outputs fed through a scoreboard queue.
module tb_fetch_redirect_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h4000_0000;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rv;
        logic [31:0] tgt;
        logic [31:0] addr;
        logic        en;
        logic [31:0] inst;
        logic [31:0] pcid;
        logic        valid;
        logic [31:0] cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        rv = 1'b0;
    logic [31:0] tgt = 32'd0;
    logic [31:0] inst_in;
    logic [31:0] mem_q = 32'd0;
    logic [31:0] imem_addr, inst_id, pc_id, redirect_cnt;
    logic        imem_en, id_valid;

    int   n_checks = 0;
    int   n_err = 0;
    int   row = 0;
    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    // Synchronous memory returning its own address as data; holds output while disabled.
    always @(posedge clk) if (imem_en) mem_q <= imem_addr;
    assign inst_in = mem_q;

    fetch_redirect_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_stall(stall),
        .i_redirect_valid(rv), .i_redirect_target(tgt), .i_inst_in(inst_in),
        .o_imem_addr(imem_addr), .o_imem_en(imem_en), .o_inst_id(inst_id),
        .o_pc_id(pc_id), .o_id_valid(id_valid), .o_redirect_cnt(redirect_cnt)
    );

    function automatic vec_t mk(logic r, logic s, logic v, logic [31:0] t, logic [31:0] a,
                                logic e, logic [31:0] i, logic [31:0] p, logic vl, logic [31:0] c);
        vec_t x;
        x.rst = r; x.stall = s; x.rv = v; x.tgt = t; x.addr = a;
        x.en = e; x.inst = i; x.pcid = p; x.valid = vl; x.cnt = c;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // Drive one cycle's inputs, queue its expectation, then compare once outputs settle.
    task automatic apply(input vec_t v);
        vec_t e;
        rst = v.rst; stall = v.stall; rv = v.rv; tgt = v.tgt;
        sb.push_back(v);
        #1;
        if (sb.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL scoreboard row %0d: got empty queue expected entry", row);
        end else begin
            e = sb.pop_front();
            chk("imem_addr", imem_addr, e.addr);
            chk("imem_en", {31'd0, imem_en}, {31'd0, e.en});
            chk("inst_id", inst_id, e.inst);
            chk("pc_id", pc_id, e.pcid);
            chk("id_valid", {31'd0, id_valid}, {31'd0, e.valid});
            chk("redirect_cnt", redirect_cnt, e.cnt);
        end
        @(negedge clk);
        row++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //                rst  stl  rv   tgt            addr           en   inst           pc_id          vld  cnt
        tbl.push_back(mk(1'b1,1'b0,1'b0,32'h0,         RPC,           1'b1,NOP,           32'h0,         1'b0,32'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,32'h0,         RPC,           1'b1,NOP,           32'h0,         1'b0,32'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,32'h0,         32'h4000_0004, 1'b1,32'h4000_0000, 32'h4000_0000, 1'b1,32'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,32'h0,         32'h4000_0008, 1'b1,32'h4000_0004, 32'h4000_0004, 1'b1,32'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,32'h0,         32'h4000_000C, 1'b1,32'h4000_0008, 32'h4000_0008, 1'b1,32'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,32'h0,         32'h4000_0010, 1'b1,32'h4000_000C, 32'h4000_000C, 1'b1,32'd0));
        // redirect to an unaligned target: two bubbles, low bits dropped
        tbl.push_back(mk(1'b0,1'b0,1'b1,32'h1000_0002, 32'h4000_0014, 1'b1,NOP,           32'h4000_0010, 1'b0,32'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,32'h0,         32'h1000_0000, 1'b1,NOP,           32'h4000_0014, 1'b0,32'd1));
        tbl.push_back(mk(1'b0,1'b0,1'b0,32'h0,         32'h1000_0004, 1'b1,32'h1000_0000, 32'h1000_0000, 1'b1,32'd1));
        tbl.push_back(mk(1'b0,1'b0,1'b0,32'h0,         32'h1000_0008, 1'b1,32'h1000_0004, 32'h1000_0004, 1'b1,32'd1));
        // back-to-back redirects
        tbl.push_back(mk(1'b0,1'b0,1'b1,32'h0000_0100, 32'h1000_000C, 1'b1,NOP,           32'h1000_0008, 1'b0,32'd1));
        tbl.push_back(mk(1'b0,1'b0,1'b1,32'h0000_0200, 32'h0000_0100, 1'b1,NOP,           32'h1000_000C, 1'b0,32'd2));
        tbl.push_back(mk(1'b0,1'b0,1'b0,32'h0,         32'h0000_0200, 1'b1,NOP,           32'h0000_0100, 1'b0,32'd3));
        tbl.push_back(mk(1'b0,1'b0,1'b0,32'h0,         32'h0000_0204, 1'b1,32'h0000_0200, 32'h0000_0200, 1'b1,32'd3));
        // stall with redirect held for three cycles
        tbl.push_back(mk(1'b0,1'b1,1'b1,32'h0000_0300, 32'h0000_0208, 1'b0,NOP,           32'h0000_0204, 1'b0,32'd3));
        tbl.push_back(mk(1'b0,1'b1,1'b1,32'h0000_0300, 32'h0000_0208, 1'b0,NOP,           32'h0000_0204, 1'b0,32'd3));
        tbl.push_back(mk(1'b0,1'b1,1'b1,32'h0000_0300, 32'h0000_0208, 1'b0,NOP,           32'h0000_0204, 1'b0,32'd3));
        tbl.push_back(mk(1'b0,1'b0,1'b1,32'h0000_0300, 32'h0000_0208, 1'b1,NOP,           32'h0000_0204, 1'b0,32'd3));
        tbl.push_back(mk(1'b0,1'b0,1'b0,32'h0,         32'h0000_0300, 1'b1,NOP,           32'h0000_0208, 1'b0,32'd4));
        tbl.push_back(mk(1'b0,1'b0,1'b0,32'h0,         32'h0000_0304, 1'b1,32'h0000_0300, 32'h0000_0300, 1'b1,32'd4));
        // stall while kill is pending keeps the bubble
        tbl.push_back(mk(1'b0,1'b0,1'b1,32'h0000_0400, 32'h0000_0308, 1'b1,NOP,           32'h0000_0304, 1'b0,32'd4));
        tbl.push_back(mk(1'b0,1'b1,1'b0,32'h0,         32'h0000_0400, 1'b0,NOP,           32'h0000_0308, 1'b0,32'd5));
        tbl.push_back(mk(1'b0,1'b0,1'b0,32'h0,         32'h0000_0400, 1'b1,NOP,           32'h0000_0308, 1'b0,32'd5));
        tbl.push_back(mk(1'b0,1'b0,1'b0,32'h0,         32'h0000_0404, 1'b1,32'h0000_0400, 32'h0000_0400, 1'b1,32'd5));
        // reset while kill pending and stalled, then boot bubble under stall
        tbl.push_back(mk(1'b0,1'b0,1'b1,32'h0000_0500, 32'h0000_0408, 1'b1,NOP,           32'h0000_0404, 1'b0,32'd5));
        tbl.push_back(mk(1'b1,1'b1,1'b0,32'h0,         RPC,           1'b0,NOP,           32'h0,         1'b0,32'd0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,32'h0,         RPC,           1'b0,NOP,           32'h0,         1'b0,32'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,32'h0,         RPC,           1'b1,NOP,           32'h0,         1'b0,32'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,32'h0,         32'h4000_0004, 1'b1,32'h4000_0000, 32'h4000_0000, 1'b1,32'd0));

        @(negedge clk);
        @(negedge clk);
        foreach (tbl[i]) apply(tbl[i]);

        // Counter wrap: preload all-ones, then one accepted redirect.
        force dut.r_redirect_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_redirect_cnt;
        apply(mk(1'b0,1'b0,1'b1,32'h0000_0600, 32'h4000_0008, 1'b1,NOP,           32'h4000_0004, 1'b0,32'hFFFF_FFFF));
        apply(mk(1'b0,1'b0,1'b0,32'h0,         32'h0000_0600, 1'b1,NOP,           32'h4000_0008, 1'b0,32'd0));
        apply(mk(1'b0,1'b0,1'b0,32'h0,         32'h0000_0604, 1'b1,32'h0000_0600, 32'h0000_0600, 1'b1,32'd0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
